// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared constants: status, icodes, ALU functions, condition codes, RNONE.
package y86_pkg;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [3:0] RNONE = 4'hF;

    // CC register value after reset: {ZF,SF,OF}
    localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - Combinational 64-bit Y86 ALU computing result and ZF/SF/OF.
module alu
    import y86_pkg::*;
(
    input  logic [63:0] aluA,
    input  logic [63:0] aluB,
    input  logic [3:0]  alufun,
    output logic [63:0] result,
    output logic        zf,
    output logic        sf,
    output logic        of
);

    always_comb begin
        result = 64'd0;
        of     = 1'b0;
        case (alufun)
            ALU_ADD: begin
                result = aluB + aluA;
                of     = (aluA[63] == aluB[63]) && (result[63] != aluB[63]);
            end
            ALU_SUB: begin
                result = aluB - aluA;
                of     = (aluA[63] != aluB[63]) && (result[63] != aluB[63]);
            end
            ALU_AND: result = aluB & aluA;
            ALU_XOR: result = aluB ^ aluA;
            default: result = 64'd0;
        endcase
    end

    assign zf = (result == 64'd0);
    assign sf = result[63];

endmodule

// File: rtl/execute.sv
// rtl/execute.sv - Y86-64 execute stage: ALU operand select, CC register, branch condition, M pipeline register.
module execute
    import y86_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         E_stat,
    input  logic [3:0]         E_icode,
    input  logic [3:0]         E_ifun,
    input  logic signed [63:0] E_valC,
    input  logic signed [63:0] E_valA,
    input  logic signed [63:0] E_valB,
    input  logic [3:0]         E_dstE,
    input  logic [3:0]         E_dstM,
    input  logic               M_bubble,
    input  logic [2:0]         m_stat,
    input  logic [2:0]         W_stat,
    output logic [2:0]         M_stat,
    output logic [3:0]         M_icode,
    output logic               M_cnd,
    output logic [63:0]        M_valE,
    output logic [63:0]        M_valA,
    output logic [3:0]         M_dstE,
    output logic [3:0]         M_dstM,
    output logic [63:0]        e_valE,
    output logic [3:0]         e_dstE,
    output logic               e_cnd
);

    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [3:0]  alu_fun;
    logic        new_zf, new_sf, new_of;
    logic [2:0]  cc;
    logic        zf, sf, of;
    logic        set_cc;

    always_comb begin
        alu_a = 64'd0;
        case (E_icode)
            I_CMOVXX, I_OPQ:             alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
            I_CALL, I_PUSHQ:             alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
            I_RET, I_POPQ:               alu_a = 64'd8;
            default:                     alu_a = 64'd0;
        endcase
    end

    always_comb begin
        alu_b = 64'd0;
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = E_valB;
            default: alu_b = 64'd0;
        endcase
    end

    assign alu_fun = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;

    alu u_alu (
        .aluA   (alu_a),
        .aluB   (alu_b),
        .alufun (alu_fun),
        .result (e_valE),
        .zf     (new_zf),
        .sf     (new_sf),
        .of     (new_of)
    );

    // Only a downstream exception blocks the flag write; M_bubble and E_stat do not
    assign set_cc = (E_icode == I_OPQ) && (m_stat == STAT_AOK) && (W_stat == STAT_AOK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc <= CC_RESET;
        end else if (set_cc) begin
            cc <= {new_zf, new_sf, new_of};
        end
    end

    assign {zf, sf, of} = cc;

    always_comb begin
        e_cnd = 1'b0;
        case (E_ifun)
            C_YES:   e_cnd = 1'b1;
            C_LE:    e_cnd = (sf ^ of) | zf;
            C_L:     e_cnd = sf ^ of;
            C_E:     e_cnd = zf;
            C_NE:    e_cnd = ~zf;
            C_GE:    e_cnd = ~(sf ^ of);
            C_G:     e_cnd = ~(sf ^ of) & ~zf;
            default: e_cnd = 1'b0;
        endcase
    end

    assign e_dstE = ((E_icode == I_CMOVXX) && !e_cnd) ? RNONE : E_dstE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || M_bubble) begin
            M_stat  <= STAT_AOK;
            M_icode <= I_NOP;
            M_cnd   <= 1'b0;
            M_valE  <= 64'd0;
            M_valA  <= 64'd0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
        end else begin
            M_stat  <= E_stat;
            M_icode <= E_icode;
            M_cnd   <= e_cnd;
            M_valE  <= e_valE;
            M_valA  <= E_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= E_dstM;
        end
    end

endmodule

// File: tb/tb_execute.sv
// tb/tb_execute.sv - Directed self-checking bench for the Y86-64 execute stage.
module tb_execute;
    import y86_pkg::*;

    logic               clk;
    logic               rst_n;
    logic [2:0]         E_stat;
    logic [3:0]         E_icode;
    logic [3:0]         E_ifun;
    logic signed [63:0] E_valC;
    logic signed [63:0] E_valA;
    logic signed [63:0] E_valB;
    logic [3:0]         E_dstE;
    logic [3:0]         E_dstM;
    logic               M_bubble;
    logic [2:0]         m_stat;
    logic [2:0]         W_stat;
    logic [2:0]         M_stat;
    logic [3:0]         M_icode;
    logic               M_cnd;
    logic [63:0]        M_valE;
    logic [63:0]        M_valA;
    logic [3:0]         M_dstE;
    logic [3:0]         M_dstM;
    logic [63:0]        e_valE;
    logic [3:0]         e_dstE;
    logic               e_cnd;

    int checks = 0;
    int errors = 0;

    execute dut (
        .clk(clk), .rst_n(rst_n),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .M_bubble(M_bubble), .m_stat(m_stat), .W_stat(W_stat),
        .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the E register and lets combinational outputs settle
    task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] va, input logic [63:0] vb,
                         input logic [63:0] vc, input logic [3:0] de);
        E_stat  = STAT_AOK;
        E_icode = icode;
        E_ifun  = ifun;
        E_valA  = va;
        E_valB  = vb;
        E_valC  = vc;
        E_dstE  = de;
        E_dstM  = RNONE;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; M_bubble = 1'b0; m_stat = STAT_AOK; W_stat = STAT_AOK;
        drive(I_JXX, C_E, 64'd0, 64'd0, 64'd0, RNONE);
        tick();
        checks++; if (M_stat !== STAT_AOK) begin errors++; $display("FAIL reset_M_stat got %0d exp %0d", M_stat, STAT_AOK); end
        checks++; if (M_icode !== I_NOP) begin errors++; $display("FAIL reset_M_icode got %h exp %h", M_icode, I_NOP); end
        checks++; if (M_cnd !== 1'b0) begin errors++; $display("FAIL reset_M_cnd got %b exp 0", M_cnd); end
        checks++; if (M_valE !== 64'd0 || M_valA !== 64'd0) begin errors++; $display("FAIL reset_M_vals got %h/%h exp 0/0", M_valE, M_valA); end
        checks++; if (M_dstE !== RNONE || M_dstM !== RNONE) begin errors++; $display("FAIL reset_M_dst got %h/%h exp f/f", M_dstE, M_dstM); end
        checks++; if (e_cnd !== 1'b1) begin errors++; $display("FAIL reset_cc_zf got %b exp 1", e_cnd); end
        drive(I_JXX, C_L, 64'd0, 64'd0, 64'd0, RNONE);
        checks++; if (e_cnd !== 1'b0) begin errors++; $display("FAIL reset_cc_l got %b exp 0", e_cnd); end
        rst_n = 1'b1;
    endtask

    task automatic test_sub_zero();
        drive(I_OPQ, ALU_ADD, 64'd1, 64'd2, 64'd0, 4'h2);
        checks++; if (e_valE !== 64'd3) begin errors++; $display("FAIL add_1_2 got %h exp 3", e_valE); end
        tick();
        drive(I_JXX, C_E, 64'd0, 64'd0, 64'd0, RNONE);
        checks++; if (e_cnd !== 1'b0) begin errors++; $display("FAIL add_zf_clear got %b exp 0", e_cnd); end
        drive(I_OPQ, ALU_SUB, 64'd5, 64'd5, 64'd0, 4'h2);
        checks++; if (e_valE !== 64'd0) begin errors++; $display("FAIL sub_5_5 got %h exp 0", e_valE); end
        tick();
        checks++; if (M_icode !== I_OPQ || M_valE !== 64'd0 || M_valA !== 64'd5 || M_dstE !== 4'h2) begin
            errors++; $display("FAIL sub_M_reg got icode %h valE %h valA %h dstE %h exp 6/0/5/2", M_icode, M_valE, M_valA, M_dstE); end
        drive(I_JXX, C_E, 64'd0, 64'd0, 64'd0, RNONE);
        checks++; if (e_cnd !== 1'b1) begin errors++; $display("FAIL jxx_e_after_sub got %b exp 1", e_cnd); end
        drive(I_JXX, C_LE, 64'd0, 64'd0, 64'd0, RNONE);
        checks++; if (e_cnd !== 1'b1) begin errors++; $display("FAIL jxx_le_after_sub got %b exp 1", e_cnd); end
        drive(I_JXX, C_E, 64'd0, 64'd0, 64'd0, RNONE);
        tick();
        checks++; if (M_cnd !== 1'b1 || M_icode !== I_JXX) begin errors++; $display("FAIL jxx_M_cnd got %b icode %h exp 1/7", M_cnd, M_icode); end
    endtask

    task automatic test_flags();
        drive(I_OPQ, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h1);
        checks++; if (e_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL add_ovf_valE got %h exp fffffffffffffffe", e_valE); end
        tick();
        // ZF=0 SF=1 OF=1: SF^OF=0
        drive(I_JXX, C_E, 64'd0, 64'd0, 64'd0, RNONE);
        checks++; if (e_cnd !== 1'b0) begin errors++; $display("FAIL ovf_e got %b exp 0", e_cnd); end
        drive(I_JXX, C_L, 64'd0, 64'd0, 64'd0, RNONE);
        checks++; if (e_cnd !== 1'b0) begin errors++; $display("FAIL ovf_l got %b exp 0", e_cnd); end
        drive(I_JXX, C_G, 64'd0, 64'd0, 64'd0, RNONE);
        checks++; if (e_cnd !== 1'b1) begin errors++; $display("FAIL ovf_g got %b exp 1", e_cnd); end
        for (int f = 7; f < 16; f++) begin
            drive(I_JXX, 4'(f), 64'd0, 64'd0, 64'd0, RNONE);
            checks++; if (e_cnd !== 1'b0) begin errors++; $display("FAIL ifun_%0d_cnd got %b exp 0", f, e_cnd); end
        end
        drive(I_OPQ, ALU_SUB, 64'd2, 64'd1, 64'd0, 4'h1);
        checks++; if (e_valE !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sub_neg got %h exp ffffffffffffffff", e_valE); end
        tick();
        drive(I_JXX, C_L, 64'd0, 64'd0, 64'd0, RNONE);
        checks++; if (e_cnd !== 1'b1) begin errors++; $display("FAIL sub_neg_l got %b exp 1", e_cnd); end
        drive(I_OPQ, ALU_SUB, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 4'h1);
        checks++; if (e_valE !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sub_ovf got %h exp 7fffffffffffffff", e_valE); end
        tick();
        drive(I_JXX, C_L, 64'd0, 64'd0, 64'd0, RNONE);
        checks++; if (e_cnd !== 1'b1) begin errors++; $display("FAIL sub_ovf_l got %b exp 1", e_cnd); end
        drive(I_OPQ, ALU_AND, 64'hF0F0, 64'hFF00, 64'd0, 4'h1);
        checks++; if (e_valE !== 64'hF000) begin errors++; $display("FAIL and got %h exp f000", e_valE); end
    endtask

    task automatic test_operand_select();
        drive(I_IRMOVQ, 4'h0, 64'd9, 64'd7, 64'd100, 4'h1);
        checks++; if (e_valE !== 64'd100) begin errors++; $display("FAIL irmovq got %0d exp 100", e_valE); end
        drive(I_MRMOVQ, 4'h0, 64'd9, 64'd100, 64'd16, 4'h1);
        checks++; if (e_valE !== 64'd116) begin errors++; $display("FAIL mrmovq got %0d exp 116", e_valE); end
        drive(I_POPQ, 4'h0, 64'd9, 64'd64, 64'd16, 4'h4);
        checks++; if (e_valE !== 64'd72) begin errors++; $display("FAIL popq got %0d exp 72", e_valE); end
        drive(I_CALL, 4'h0, 64'd9, 64'd64, 64'd16, 4'h4);
        checks++; if (e_valE !== 64'd56) begin errors++; $display("FAIL call got %0d exp 56", e_valE); end
        drive(I_HALT, 4'h0, 64'd9, 64'd64, 64'd16, 4'h4);
        checks++; if (e_valE !== 64'd0) begin errors++; $display("FAIL halt got %0d exp 0", e_valE); end
    endtask

    task automatic test_cmov();
        drive(I_OPQ, ALU_SUB, 64'd5, 64'd5, 64'd0, 4'h2);
        tick();
        drive(I_CMOVXX, C_NE, 64'h1234, 64'd99, 64'd0, 4'h3);
        checks++; if (e_dstE !== RNONE) begin errors++; $display("FAIL cmov_ne_e_dstE got %h exp f", e_dstE); end
        tick();
        checks++; if (M_dstE !== RNONE) begin errors++; $display("FAIL cmov_ne_M_dstE got %h exp f", M_dstE); end
        drive(I_CMOVXX, C_E, 64'h1234, 64'd99, 64'd0, 4'h3);
        checks++; if (e_dstE !== 4'h3) begin errors++; $display("FAIL cmov_e_e_dstE got %h exp 3", e_dstE); end
        tick();
        checks++; if (M_valE !== 64'h1234 || M_dstE !== 4'h3 || M_cnd !== 1'b1) begin
            errors++; $display("FAIL cmov_e_M got valE %h dstE %h cnd %b exp 1234/3/1", M_valE, M_dstE, M_cnd); end
    endtask

    task automatic test_cc_inhibit();
        drive(I_OPQ, ALU_ADD, 64'd1, 64'd2, 64'd0, 4'h2);
        tick();
        m_stat = STAT_ADR;
        drive(I_OPQ, ALU_XOR, 64'hAA, 64'hAA, 64'd0, 4'h2);
        checks++; if (e_valE !== 64'd0) begin errors++; $display("FAIL xor_zero got %h exp 0", e_valE); end
        tick();
        m_stat = STAT_AOK; W_stat = STAT_HLT;
        drive(I_OPQ, ALU_XOR, 64'hAA, 64'hAA, 64'd0, 4'h2);
        tick();
        W_stat = STAT_AOK;
        drive(I_JXX, C_E, 64'd0, 64'd0, 64'd0, RNONE);
        checks++; if (e_cnd !== 1'b0) begin errors++; $display("FAIL cc_inhibited got ZF %b exp 0", e_cnd); end
        drive(I_OPQ, ALU_XOR, 64'hAA, 64'hAA, 64'd0, 4'h2);
        E_stat = STAT_INS; #1;
        tick();
        checks++; if (M_stat !== STAT_INS) begin errors++; $display("FAIL estat_pass got %0d exp 4", M_stat); end
        drive(I_JXX, C_E, 64'd0, 64'd0, 64'd0, RNONE);
        checks++; if (e_cnd !== 1'b1) begin errors++; $display("FAIL cc_updated got ZF %b exp 1", e_cnd); end
    endtask

    task automatic test_bubble();
        M_bubble = 1'b1;
        drive(I_PUSHQ, 4'h0, 64'd7, 64'd64, 64'd0, 4'h4);
        checks++; if (e_valE !== 64'd56) begin errors++; $display("FAIL pushq_e_valE got %0d exp 56", e_valE); end
        tick();
        checks++; if (M_icode !== I_NOP || M_dstE !== RNONE || M_valE !== 64'd0) begin
            errors++; $display("FAIL pushq_bubble got icode %h dstE %h valE %h exp 1/f/0", M_icode, M_dstE, M_valE); end
        M_bubble = 1'b0;
        tick();
        checks++; if (M_valE !== 64'd56 || M_icode !== I_PUSHQ || M_dstE !== 4'h4 || M_valA !== 64'd7) begin
            errors++; $display("FAIL pushq_load got valE %0d icode %h dstE %h valA %0d exp 56/a/4/7", M_valE, M_icode, M_dstE, M_valA); end
        M_bubble = 1'b1;
        drive(I_OPQ, ALU_ADD, 64'd1, 64'd2, 64'd0, 4'h2);
        tick();
        M_bubble = 1'b0;
        drive(I_JXX, C_E, 64'd0, 64'd0, 64'd0, RNONE);
        checks++; if (e_cnd !== 1'b0) begin errors++; $display("FAIL bubbled_opq_cc got ZF %b exp 0", e_cnd); end
    endtask

    task automatic test_async_reset();
        drive(I_OPQ, ALU_ADD, 64'd1, 64'd2, 64'd0, 4'h2);
        tick();
        checks++; if (M_icode !== I_OPQ) begin errors++; $display("FAIL pre_reset_icode got %h exp 6", M_icode); end
        drive(I_JXX, C_E, 64'd0, 64'd0, 64'd0, RNONE);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (M_icode !== I_NOP || M_valE !== 64'd0 || M_dstE !== RNONE || M_stat !== STAT_AOK) begin
            errors++; $display("FAIL async_reset_M got icode %h valE %h dstE %h stat %0d exp 1/0/f/1", M_icode, M_valE, M_dstE, M_stat); end
        checks++; if (e_cnd !== 1'b1) begin errors++; $display("FAIL async_reset_cc got ZF %b exp 1", e_cnd); end
        tick();
        rst_n = 1'b1;
        drive(I_OPQ, ALU_SUB, 64'd3, 64'd10, 64'd0, 4'h5);
        tick();
        checks++; if (M_valE !== 64'd7 || M_dstE !== 4'h5) begin errors++; $display("FAIL post_reset_load got valE %0d dstE %h exp 7/5", M_valE, M_dstE); end
    endtask

    initial begin
        test_reset();
        test_sub_zero();
        test_flags();
        test_operand_select();
        test_cmov();
        test_cc_inhibit();
        test_bubble();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have clk, input, 1: the single clock; all state updates on the rising edge.
REQ-002 SHALL have rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have E_stat input 3, E_icode input 4, E_ifun input 4: decode-to-execute pipeline register contents.
REQ-004 SHALL have E_valC, E_valA and E_valB, input, 64 each, signed: constant and two operands.
REQ-005 SHALL have E_dstE and E_dstM, input, 4 each: destination register IDs (4'hF = RNONE).
REQ-006 SHALL have M_bubble, input, 1: replace the next M-register load with a bubble.
REQ-007 SHALL have m_stat and W_stat, input, 3 each: downstream status, used to inhibit CC update.
REQ-008 SHALL have M_stat 3, M_icode 4, M_cnd 1, M_valE 64, M_valA 64, M_dstE 4, M_dstM 4, all outputs, registered: execute-to-memory pipeline register.
REQ-009 SHALL have e_valE 64, e_dstE 4, e_cnd 1, all outputs, combinational: forwarding and branch-resolution taps.

Function
REQ-010 SHALL use status codes AOK=1, HLT=2, ADR=3, INS=4.
REQ-011 SHALL use icodes HALT=0, NOP=1, CMOVXX=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B.
REQ-012 SHALL select ALU operand A as: valA for CMOVXX and OPQ; valC for IRMOVQ, RMMOVQ and MRMOVQ; -8 for CALL and PUSHQ; +8 for RET and POPQ; otherwise 0.
REQ-013 SHALL select ALU operand B as: valB for RMMOVQ, MRMOVQ, OPQ, CALL, PUSHQ, RET and POPQ; 0 for CMOVXX and IRMOVQ; otherwise 0.
REQ-014 SHALL use the ALU function E_ifun when icode is OPQ, and ADD otherwise.
REQ-015 SHALL encode the ALU functions as: 0 ADD B+A; 1 SUB B-A; 2 AND; 3 XOR. Arithmetic is 64-bit two's complement and wraps modulo 2^64.
REQ-016 SHALL compute the new flags: ZF = (e_valE==0); SF = e_valE[63].
REQ-017 SHALL compute OF as follows: for ADD, operands of the same sign and a result of different sign; for SUB, operands of different sign and a result sign not equal to B's sign; for AND/XOR, OF=0.
REQ-018 SHALL load the CC register {ZF,SF,OF} on a clock edge only when all of these hold: E_icode==OPQ; m_stat is AOK; W_stat is AOK.
REQ-019 SHALL keep the CC register unchanged whenever the REQ-018 condition does not hold.
REQ-020 SHALL compute e_cnd from the current (pre-update) CC and E_ifun: 0 always; 1 LE (SF^OF)|ZF; 2 L SF^OF; 3 E ZF; 4 NE !ZF; 5 GE !(SF^OF); 6 G !(SF^OF)&!ZF.
REQ-021 SHALL produce e_cnd=0 for E_ifun 7..F.
REQ-022 SHALL set e_dstE = RNONE when E_icode==CMOVXX and e_cnd==0, and e_dstE = E_dstE otherwise.
REQ-023 SHALL, on a clock edge with M_bubble=0, load M_stat<=E_stat, M_icode<=E_icode, M_cnd<=e_cnd, M_valE<=e_valE, M_valA<=E_valA, M_dstE<=e_dstE and M_dstM<=E_dstM.
REQ-024 SHALL, on a clock edge with M_bubble=1, load the bubble: M_stat=AOK, M_icode=NOP, M_cnd=0, M_valE=0, M_valA=0, M_dstE=F, M_dstM=F.
REQ-025 SHALL give 1-cycle latency from E inputs to M outputs; there is no stall input, and the stage always advances.
REQ-026 SHALL evaluate the CC update independently of M_bubble; a bubbled OPQ still updates CC when REQ-018 holds.
REQ-027 SHALL treat non-AOK E_stat like any other instruction: pass it through and do not block the CC update (only m_stat/W_stat inhibit).

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force the M register to the bubble value (REQ-024).
REQ-029 SHALL, while rst_n=0, asynchronously force CC to ZF=1, SF=0, OF=0.
REQ-030 SHALL resume normal loading at the first rising clk after rst_n deasserts; a reset asserted mid-instruction discards that instruction.

Structure
REQ-031 SHALL place the icode, ALU-function, condition-code, stat and RNONE constants in a shared package y86_pkg.
REQ-032 SHALL implement the ALU as one combinational sub-module, alu (inputs aluA, aluB, alufun; outputs result, zf, sf, of).
REQ-033 SHALL keep the CC register and the M register in the execute module itself.

Verification
REQ-034 SHALL cover: OPQ SUB, valA=5, valB=5 -> e_valE=0; after the edge, CC = ZF1 SF0 OF0.
REQ-035 SHALL cover: next JXX ifun=3 -> e_cnd=1, and M_cnd=1 one cycle later.
REQ-036 SHALL cover: OPQ ADD, valA=valB=0x7FFFFFFFFFFFFFFF -> e_valE=0xFFFFFFFFFFFFFFFE and OF=1, SF=1, ZF=0.
REQ-037 SHALL cover: CMOVXX ifun=4 with ZF=1, E_dstE=3 -> e_dstE=F and M_dstE=F; with ifun=3 -> e_dstE=3 and M_valE=valA.
REQ-038 SHALL cover: OPQ XOR producing 0 with m_stat=ADR -> CC unchanged; the same instruction with m_stat=W_stat=AOK -> ZF=1.
REQ-039 SHALL cover: PUSHQ with valB=64 and M_bubble=1 -> M_icode=NOP, M_dstE=F; with M_bubble=0 -> M_valE=56.
REQ-040 SHALL cover: assert rst_n=0 between clock edges -> M outputs go to bubble and CC goes to 100 immediately, without waiting for clk.
